sub_serial_32: RTL and testbench



---
 rtl/sub_serial_32.sv | 163 ++++++++++++++++
 tb/tb_sub_serial_32.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sub_serial_32.sv
// rtl/sub_serial_32.sv - byte-serial 32-bit subtractor built on one 8-bit carry-lookahead slice
// Computes d = a + ~b + 1 one byte per clock, carrying the borrow in a register between slices.

module cla_8 (
    output logic [7:0] o_sum,
    output logic       o_cout,
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    input  logic       i_cin
);
    logic [7:0] w_g;
    logic [7:0] w_p;
    logic [8:0] w_c;
    logic       w_term;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Each carry is formed directly from generate/propagate terms rather than rippled.
    always_comb begin
        w_c    = '0;
        w_term = 1'b0;
        w_c[0] = i_cin;
        for (int i = 0; i < 8; i++) begin
            w_term = i_cin;
            for (int k = 0; k <= i; k++) begin
                w_term = w_term & w_p[k];
            end
            w_c[i+1] = w_term;
            for (int j = 0; j <= i; j++) begin
                w_term = w_g[j];
                for (int k = j + 1; k <= i; k++) begin
                    w_term = w_term & w_p[k];
                end
                w_c[i+1] = w_c[i+1] | w_term;
            end
        end
    end

    assign o_sum  = w_p ^ w_c[7:0];
    assign o_cout = w_c[8];
endmodule

module sub_serial_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] d,
    output logic        bout,
    output logic        ovf,
    output logic        busy,
    output logic        done
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        w_accept;
    logic        w_busy;
    logic        w_done;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_d;
    logic        r_bout;
    logic        r_ovf;
    logic        r_carry;
    logic [1:0]  r_idx;

    logic [7:0]  w_a_slice;
    logic [7:0]  w_b_slice;
    logic [7:0]  w_sum;
    logic        w_cout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_busy   = 1'b0;
        w_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end
            end
            S_RUN: begin
                w_busy = 1'b1;
                if (r_idx == 2'd3) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_done = 1'b1;
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_RUN;
                end else begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_a_slice = r_a[{r_idx, 3'b000} +: 8];
    assign w_b_slice = ~r_b[{r_idx, 3'b000} +: 8];

    cla_8 u_cla (
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .i_a    (w_a_slice),
        .i_b    (w_b_slice),
        .i_cin  (r_carry)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_d     <= '0;
            r_bout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_carry <= 1'b0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b1;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            r_d[{r_idx, 3'b000} +: 8] <= w_sum;
            r_carry                   <= w_cout;
            if (r_idx == 2'd3) begin
                // Sign of the result comes from the slice being written now, not the stale byte.
                r_bout <= ~w_cout;
                r_ovf  <= (r_a[31] ^ r_b[31]) & (r_a[31] ^ w_sum[7]);
            end else begin
                r_idx <= r_idx + 2'd1;
            end
        end
    end

    assign d    = r_d;
    assign bout = r_bout;
    assign ovf  = r_ovf;
    assign busy = w_busy;
    assign done = w_done;
endmodule

// File: tb/tb_sub_serial_32.sv
// tb/tb_sub_serial_32.sv - directed-vector bench for sub_serial_32

module tb_sub_serial_32;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] d;
    logic        bout;
    logic        ovf;
    logic        busy;
    logic        done;

    int n_vec;
    int n_bad;

    sub_serial_32 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .d     (d),
        .bout  (bout),
        .ovf   (ovf),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Caller is just after a rising edge with the block idle; this cycle is cycle 0.
    task automatic run_op(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                          input logic [31:0] ed, input logic eb, input logic eo);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        check({tag, "_busy_c0"}, {31'd0, busy}, 32'd0);
        next_cycle();
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            check($sformatf("%s_busy_c%0d", tag, c), {31'd0, busy}, 32'd1);
            check($sformatf("%s_done_c%0d", tag, c), {31'd0, done}, 32'd0);
            next_cycle();
        end
        @(negedge clk);
        check({tag, "_done_c5"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_c5"}, {31'd0, busy}, 32'd0);
        check({tag, "_d"},       d,              ed);
        check({tag, "_bout"},    {31'd0, bout},  {31'd0, eb});
        check({tag, "_ovf"},     {31'd0, ovf},   {31'd0, eo});
        next_cycle();
        @(negedge clk);
        check({tag, "_done_c6"}, {31'd0, done}, 32'd0);
        next_cycle();
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_d",    d,              32'd0);
        check("rst_bout", {31'd0, bout},  32'd0);
        check("rst_ovf",  {31'd0, ovf},   32'd0);
        check("rst_busy", {31'd0, busy},  32'd0);
        check("rst_done", {31'd0, done},  32'd0);
        next_cycle();
        rst = 1'b0;
        next_cycle();

        run_op("basic",  32'h0000_0005, 32'h0000_0003, 32'h0000_0002, 1'b0, 1'b0);
        run_op("ripple", 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0);
        run_op("byte1",  32'h0000_0100, 32'h0000_0001, 32'h0000_00FF, 1'b0, 1'b0);
        run_op("negovf", 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1);
        run_op("minovf", 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1);

        // Results must hold while idle even as the operand inputs move.
        a = 32'hDEAD_BEEF;
        b = 32'h0123_4567;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check($sformatf("hold_d_%0d", c),    d,             32'h7FFF_FFFF);
            check($sformatf("hold_bout_%0d", c), {31'd0, bout}, 32'd0);
            check($sformatf("hold_ovf_%0d", c),  {31'd0, ovf},  32'd1);
            check($sformatf("hold_busy_%0d", c), {31'd0, busy}, 32'd0);
            next_cycle();
        end

        // start held high for 12 cycles: back-to-back operations.
        a     = 32'h1234_5678;
        b     = 32'h1234_5678;
        start = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            check($sformatf("b2b_done_c%0d", c), {31'd0, done},
                  ((c == 5) || (c == 10)) ? 32'd1 : 32'd0);
            if ((c == 5) || (c == 10)) begin
                check($sformatf("b2b_d_c%0d", c),    d,             32'd0);
                check($sformatf("b2b_bout_c%0d", c), {31'd0, bout}, 32'd0);
            end
            if (c == 6) begin
                check("b2b_busy_c6", {31'd0, busy}, 32'd1);
            end
            next_cycle();
        end
        start = 1'b0;
        for (int c = 0; c < 6; c++) next_cycle();
        @(negedge clk);
        check("b2b_idle_busy", {31'd0, busy}, 32'd0);
        next_cycle();

        // Reset in the middle of an operation.
        a     = 32'h0000_0100;
        b     = 32'h0000_0001;
        start = 1'b1;
        next_cycle();
        start = 1'b0;
        next_cycle();
        next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        for (int c = 4; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("abort_done_c%0d", c), {31'd0, done}, 32'd0);
            check($sformatf("abort_busy_c%0d", c), {31'd0, busy}, 32'd0);
            check($sformatf("abort_d_c%0d", c),    d,             32'd0);
            check($sformatf("abort_bout_c%0d", c), {31'd0, bout}, 32'd0);
            check($sformatf("abort_ovf_c%0d", c),  {31'd0, ovf},  32'd0);
            next_cycle();
        end

        // A start coinciding with rst is dropped.
        a     = 32'h0000_0001;
        b     = 32'h0000_0000;
        start = 1'b1;
        rst   = 1'b1;
        next_cycle();
        start = 1'b0;
        rst   = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("rststart_busy_%0d", c), {31'd0, busy}, 32'd0);
            check($sformatf("rststart_done_%0d", c), {31'd0, done}, 32'd0);
            next_cycle();
        end

        run_op("post", 32'h0000_0001, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
